// File: rtl/rs_5_3_pkg.sv
// rtl/rs_5_3_pkg.sv - shared constants, state type and helpers for the RS(5,3) frame feeder
package rs_5_3_pkg;

    localparam int RS_ENC_LEN = 3;
    localparam int RS_DEC_LEN = 5;
    localparam int RS_SYM_W   = 8;

    localparam logic RS_MODE_ENC = 1'b1;
    localparam logic RS_MODE_DEC = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } feed_state_e;

    function automatic logic [2:0] frame_len(input logic mode);
        return (mode == RS_MODE_ENC) ? 3'(RS_ENC_LEN) : 3'(RS_DEC_LEN);
    endfunction

endpackage

// File: rtl/rs_5_3_frame_slot_buf.sv
// rtl/rs_5_3_frame_slot_buf.sv - two-slot frame store with write/read pointers and full flags
// Optional error-injection fields are kept per slot when RS_FEEDER_ERR_INJ_EN is defined.
module rs_5_3_frame_slot_buf
    import rs_5_3_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                wr_valid_i,
    input  logic [RS_SYM_W-1:0] wr_data_i,
    input  logic                wr_mode_i,
`ifdef RS_FEEDER_ERR_INJ_EN
    input  logic [2:0]          wr_err_pos_i,
    input  logic [RS_SYM_W-1:0] wr_err_val_i,
    output logic [2:0]          rd_err_pos_o,
    output logic [RS_SYM_W-1:0] rd_err_val_o,
`endif
    input  logic                rd_free_i,
    input  logic [2:0]          rd_idx_i,
    output logic                wr_ready_o,
    output logic                rd_full_o,
    output logic                rd_mode_o,
    output logic [RS_SYM_W-1:0] rd_data_o,
    output logic                any_full_next_o
);

    logic [RS_SYM_W-1:0] mem_q [2][RS_DEC_LEN];
    logic [1:0]          mode_q;
    logic [1:0]          full_q, full_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [2:0]          wr_cnt_q, wr_cnt_d;
    logic                ready_q;
    logic                wr_fire;
    logic                first_sym;
    logic                cur_mode;

`ifdef RS_FEEDER_ERR_INJ_EN
    logic [2:0]          err_pos_q [2];
    logic [RS_SYM_W-1:0] err_val_q [2];
`endif

    assign wr_fire   = wr_valid_i && ready_q;
    assign first_sym = (wr_cnt_q == 3'd0);
    // The frame length is fixed by the mode latched with the first symbol.
    assign cur_mode  = first_sym ? wr_mode_i : mode_q[wr_ptr_q];

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_cnt_d = wr_cnt_q;
        if (wr_fire) begin
            if (wr_cnt_q == frame_len(cur_mode) - 3'd1) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_cnt_d         = 3'd0;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 3'd1;
            end
        end
        if (rd_free_i) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_cnt_q <= 3'd0;
            ready_q  <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            ready_q  <= ~full_d[wr_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q][wr_cnt_q] <= wr_data_i;
            if (first_sym) begin
                mode_q[wr_ptr_q] <= wr_mode_i;
`ifdef RS_FEEDER_ERR_INJ_EN
                err_pos_q[wr_ptr_q] <= wr_err_pos_i;
                err_val_q[wr_ptr_q] <= (wr_mode_i == RS_MODE_DEC) ? wr_err_val_i : '0;
`endif
            end
        end
    end

    assign wr_ready_o      = ready_q;
    assign rd_full_o       = full_q[rd_ptr_q];
    assign rd_mode_o       = mode_q[rd_ptr_q];
    assign rd_data_o       = mem_q[rd_ptr_q][rd_idx_i];
    assign any_full_next_o = |full_d;
`ifdef RS_FEEDER_ERR_INJ_EN
    assign rd_err_pos_o    = err_pos_q[rd_ptr_q];
    assign rd_err_val_o    = err_val_q[rd_ptr_q];
`endif

endmodule

// File: rtl/rs_5_3_frame_feeder.sv
// rtl/rs_5_3_frame_feeder.sv - frames a byte stream into gapped RS(5,3) codec bursts
// Optional macro RS_FEEDER_ERR_INJ_EN adds ERR_POS/ERR_VAL symbol corruption on decode frames.
module rs_5_3_frame_feeder
    import rs_5_3_pkg::*;
#(
    parameter int ENC_GAP = 2,
    parameter int DEC_GAP = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                S_VALID,
    output logic                S_READY,
    input  logic [RS_SYM_W-1:0] S_DATA,
    input  logic                S_MODE,
`ifdef RS_FEEDER_ERR_INJ_EN
    input  logic [2:0]          ERR_POS,
    input  logic [RS_SYM_W-1:0] ERR_VAL,
`endif
    output logic                DATA_VALID_IN,
    output logic [RS_SYM_W-1:0] DATA_IN,
    output logic                E_D,
    output logic                BUSY
);

    // Outputs lag the state by one register, so the IDLE cycle before a burst
    // counts as one of the idle cycles and GAP itself lasts gap-1 cycles.
    localparam logic [7:0] ENC_RELOAD = (ENC_GAP >= 2) ? 8'(ENC_GAP - 2) : 8'd0;
    localparam logic [7:0] DEC_RELOAD = (DEC_GAP >= 2) ? 8'(DEC_GAP - 2) : 8'd0;

    feed_state_e         state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          gap_q, gap_d;
    logic                dv_q, dv_d;
    logic [RS_SYM_W-1:0] data_q, data_d;
    logic                ed_q, ed_d;
    logic                busy_q, busy_d;

    logic                rd_free;
    logic                rd_full;
    logic                rd_mode;
    logic [RS_SYM_W-1:0] rd_data;
    logic                any_full_next;
    logic                wr_ready;
    logic [RS_SYM_W-1:0] inj_mask;

`ifdef RS_FEEDER_ERR_INJ_EN
    logic [2:0]          rd_err_pos;
    logic [RS_SYM_W-1:0] rd_err_val;

    assign inj_mask = (rd_mode == RS_MODE_DEC && rd_err_pos == idx_q) ? rd_err_val : '0;
`else
    assign inj_mask = '0;
`endif

    rs_5_3_frame_slot_buf u_slots (
        .clk_i           (CLK),
        .reset_i         (RESET),
        .wr_valid_i      (S_VALID),
        .wr_data_i       (S_DATA),
        .wr_mode_i       (S_MODE),
`ifdef RS_FEEDER_ERR_INJ_EN
        .wr_err_pos_i    (ERR_POS),
        .wr_err_val_i    (ERR_VAL),
        .rd_err_pos_o    (rd_err_pos),
        .rd_err_val_o    (rd_err_val),
`endif
        .rd_free_i       (rd_free),
        .rd_idx_i        (idx_q),
        .wr_ready_o      (wr_ready),
        .rd_full_o       (rd_full),
        .rd_mode_o       (rd_mode),
        .rd_data_o       (rd_data),
        .any_full_next_o (any_full_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        dv_d    = 1'b1;
        data_d  = '0;
        ed_d    = ed_q;
        rd_free = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_full) begin
                    state_d = BURST;
                    idx_d   = 3'd0;
                end
            end
            BURST: begin
                dv_d   = 1'b0;
                data_d = rd_data ^ inj_mask;
                if (idx_q == 3'd0) begin
                    ed_d = rd_mode;
                end
                if (idx_q == frame_len(rd_mode) - 3'd1) begin
                    rd_free = 1'b1;
                    state_d = GAP;
                    gap_d   = (rd_mode == RS_MODE_ENC) ? ENC_RELOAD : DEC_RELOAD;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = any_full_next || (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            gap_q   <= 8'd0;
            dv_q    <= 1'b1;
            data_q  <= '0;
            ed_q    <= RS_MODE_ENC;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            ed_q    <= ed_d;
            busy_q  <= busy_d;
        end
    end

    assign S_READY       = wr_ready;
    assign DATA_VALID_IN = dv_q;
    assign DATA_IN       = data_q;
    assign E_D           = ed_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_rs_5_3_frame_feeder.sv
// tb/tb_rs_5_3_frame_feeder.sv - self-checking bench for rs_5_3_frame_feeder
module tb_rs_5_3_frame_feeder;

    logic       CLK = 1'b0;
    logic       RESET, S_VALID, S_READY, S_MODE, DATA_VALID_IN, E_D, BUSY;
    logic [7:0] S_DATA, DATA_IN;
`ifdef RS_FEEDER_ERR_INJ_EN
    logic [2:0] ERR_POS = 3'd7;
    logic [7:0] ERR_VAL = 8'd0;
`endif

    always #5 CLK = ~CLK;

    rs_5_3_frame_feeder dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .S_VALID       (S_VALID),
        .S_READY       (S_READY),
        .S_DATA        (S_DATA),
        .S_MODE        (S_MODE),
`ifdef RS_FEEDER_ERR_INJ_EN
        .ERR_POS       (ERR_POS),
        .ERR_VAL       (ERR_VAL),
`endif
        .DATA_VALID_IN (DATA_VALID_IN),
        .DATA_IN       (DATA_IN),
        .E_D           (E_D),
        .BUSY          (BUSY)
    );

    typedef struct {
        logic       mode;
        int         len;
        logic [7:0] syms [5];
    } frame_t;

    typedef struct {
        logic       ed;
        int         len;
        logic [7:0] syms [5];
        int         start;
        int         idle;
    } burst_t;

    typedef struct {
        logic       mode;
        logic [7:0] s [5];
        logic       exp_ed;
        int         exp_len;
        logic [7:0] exp_s [5];
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     max_stall = 0;
    burst_t obs [$];
    burst_t cur;
    logic   in_burst = 1'b0;
    logic   prev_ed = 1'b1;
    int     idle_cnt = 1000;
    int     ed_glitch = 0;
    int     data_nz = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Passive monitor: records every observed burst, idle run length and E_D behaviour.
    always @(negedge CLK) begin
        #1;
        if (!RESET && E_D !== prev_ed && !(DATA_VALID_IN === 1'b0 && !in_burst)) ed_glitch++;
        prev_ed = E_D;
        if (DATA_VALID_IN === 1'b0) begin
            if (!in_burst) begin
                in_burst  = 1'b1;
                cur.ed    = E_D;
                cur.len   = 0;
                cur.start = cyc;
                cur.idle  = idle_cnt;
            end
            if (cur.len < 5) cur.syms[cur.len] = DATA_IN;
            cur.len++;
        end else begin
            if (in_burst) begin
                obs.push_back(cur);
                in_burst = 1'b0;
                idle_cnt = 0;
            end
            idle_cnt++;
            if (!RESET && DATA_IN !== 8'h00) data_nz++;
        end
        if (RESET) idle_cnt = 1000;
    end

    function automatic int gap_of(input logic ed);
        return ed ? 2 : 6;
    endfunction

    function automatic int len_of(input logic mode);
        return mode ? 3 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int req);
        checks++;
        if (act < req) begin
            errors++;
            $display("FAIL %s: got %0d required at least %0d", name, act, req);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int req);
        checks++;
        if (act > req) begin
            errors++;
            $display("FAIL %s: got %0d required at most %0d", name, act, req);
        end
    endtask

    task automatic put_sym(input logic [7:0] d, input logic m, output int acc);
        int t = 0;
        S_VALID = 1'b1;
        S_DATA  = d;
        S_MODE  = m;
        while (S_READY !== 1'b1 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 32'(t), 32'd0);
        if (t > max_stall) max_stall = t;
        acc = cyc + 1;
        @(negedge CLK);
    endtask

    task automatic send_frame(input frame_t f, input bit bubbles, output int last_acc);
        for (int i = 0; i < f.len; i++) begin
            if (bubbles) begin
                int n = int'($urandom_range(0, 2));
                for (int b = 0; b < n; b++) begin
                    S_VALID = 1'b0;
                    @(negedge CLK);
                end
            end
            put_sym(f.syms[i], (i == 0) ? f.mode : 1'($urandom), last_acc);
        end
    endtask

    task automatic wait_obs(input string name, input int n, input int budget);
        int t = 0;
        while (obs.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        chk_ge({name, "_bursts_seen"}, obs.size(), n);
    endtask

    task automatic cmp_burst(input string tag, input int k, input frame_t f);
        if (k >= obs.size()) begin
            chk_ge({tag, "_present"}, obs.size(), k + 1);
            return;
        end
        chk({tag, "_ed"}, 32'(obs[k].ed), 32'(f.mode));
        chk({tag, "_len"}, 32'(obs[k].len), 32'(f.len));
        for (int i = 0; i < f.len; i++)
            chk($sformatf("%s_sym%0d", tag, i), 32'(obs[k].syms[i]), 32'(f.syms[i]));
    endtask

    function automatic frame_t rand_frame(input logic mode);
        frame_t f;
        f.mode = mode;
        f.len  = len_of(mode);
        for (int i = 0; i < 5; i++) f.syms[i] = 8'($urandom);
        return f;
    endfunction

    initial begin
        vec_t   vecs [5];
        frame_t fq [$];
        frame_t f;
        int     acc;
        int     t;

        vecs[0] = '{mode: 1'b1, s: '{8'h50, 8'h00, 8'h00, 8'h00, 8'h00}, exp_ed: 1'b1, exp_len: 3,
                    exp_s: '{8'h50, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{mode: 1'b0, s: '{8'h50, 8'h00, 8'h00, 8'hC3, 8'hA1}, exp_ed: 1'b0, exp_len: 5,
                    exp_s: '{8'h50, 8'h00, 8'h00, 8'hC3, 8'hA1}};
        vecs[2] = '{mode: 1'b1, s: '{8'hFF, 8'h01, 8'h80, 8'h00, 8'h00}, exp_ed: 1'b1, exp_len: 3,
                    exp_s: '{8'hFF, 8'h01, 8'h80, 8'h00, 8'h00}};
        vecs[3] = '{mode: 1'b0, s: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, exp_ed: 1'b0, exp_len: 5,
                    exp_s: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}};
        vecs[4] = '{mode: 1'b1, s: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, exp_ed: 1'b1, exp_len: 3,
                    exp_s: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        RESET = 1'b1; S_VALID = 1'b0; S_DATA = 8'h00; S_MODE = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_dv", 32'(DATA_VALID_IN), 32'd1);
        chk("reset_data", 32'(DATA_IN), 32'd0);
        chk("reset_ed", 32'(E_D), 32'd1);
        chk("reset_ready", 32'(S_READY), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(S_READY), 32'd1);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            obs.delete();
            f.mode = vecs[v].mode;
            f.len  = len_of(vecs[v].mode);
            f.syms = vecs[v].s;
            send_frame(f, 1'b0, acc);
            S_VALID = 1'b0;
            wait_obs($sformatf("vec%0d", v), 1, 100);
            f.mode = vecs[v].exp_ed;
            f.len  = vecs[v].exp_len;
            f.syms = vecs[v].exp_s;
            cmp_burst($sformatf("vec%0d", v), 0, f);
            if (v == 0 && obs.size() > 0) chk("latency", 32'(obs[0].start), 32'(acc + 2));
            if (v > 0 && obs.size() > 0) chk_ge($sformatf("vec%0d_gap", v), obs[0].idle, gap_of(vecs[v-1].exp_ed));
        end
        repeat (8) @(negedge CLK);

        // Back-to-back encode frames with S_VALID held high
        obs.delete(); fq.delete(); max_stall = 0;
        for (int k = 0; k < 4; k++) begin
            f = rand_frame(1'b1);
            fq.push_back(f);
            send_frame(f, 1'b0, acc);
        end
        S_VALID = 1'b0;
        wait_obs("b2b_enc", 4, 100);
        for (int k = 0; k < 4; k++) cmp_burst($sformatf("b2b_enc%0d", k), k, fq[k]);
        for (int k = 1; k < 4 && k < obs.size(); k++)
            chk($sformatf("b2b_enc_period%0d", k), 32'(obs[k].start - obs[k-1].start), 32'd5);
        chk_le("b2b_enc_max_stall", max_stall, 5);
        repeat (12) @(negedge CLK);

        // Back-to-back decode frames, third one refills a freed slot
        obs.delete(); fq.delete();
        for (int k = 0; k < 3; k++) begin
            f = rand_frame(1'b0);
            fq.push_back(f);
            send_frame(f, 1'b0, acc);
        end
        S_VALID = 1'b0;
        wait_obs("b2b_dec", 3, 150);
        for (int k = 0; k < 3; k++) cmp_burst($sformatf("b2b_dec%0d", k), k, fq[k]);
        for (int k = 1; k < 3 && k < obs.size(); k++)
            chk($sformatf("b2b_dec_period%0d", k), 32'(obs[k].start - obs[k-1].start), 32'd11);
        repeat (12) @(negedge CLK);

        // Mode switch: encode immediately followed by decode
        obs.delete(); fq.delete();
        fq.push_back(rand_frame(1'b1));
        fq.push_back(rand_frame(1'b0));
        send_frame(fq[0], 1'b0, acc);
        send_frame(fq[1], 1'b0, acc);
        S_VALID = 1'b0;
        wait_obs("switch", 2, 100);
        cmp_burst("switch_enc", 0, fq[0]);
        cmp_burst("switch_dec", 1, fq[1]);
        if (obs.size() > 1) chk_ge("switch_gap", obs[1].idle, 2);
        repeat (12) @(negedge CLK);

        // Reset in the second cycle of a decode burst
        obs.delete();
        f = rand_frame(1'b0);
        send_frame(f, 1'b0, acc);
        S_VALID = 1'b0;
        t = 0;
        while (DATA_VALID_IN !== 1'b0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk_le("rst_burst_seen", t, 49);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_dv", 32'(DATA_VALID_IN), 32'd1);
        chk("rst_ready", 32'(S_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_trunc_len", (obs.size() > 0) ? 32'(obs[0].len) : 32'hFFFF_FFFF, 32'd2);
        obs.delete();
        f = rand_frame(1'b1);
        send_frame(f, 1'b0, acc);
        S_VALID = 1'b0;
        wait_obs("post_rst", 1, 50);
        cmp_burst("post_rst", 0, f);
        if (obs.size() > 0) chk("post_rst_latency", 32'(obs[0].start), 32'(acc + 2));
        repeat (8) @(negedge CLK);

        // Randomized frames with bubbles against the frame-queue model
        obs.delete(); fq.delete();
        for (int k = 0; k < 24; k++) begin
            f = rand_frame(1'($urandom));
            fq.push_back(f);
            send_frame(f, 1'b1, acc);
            if ($urandom_range(0, 3) == 0) begin
                S_VALID = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge CLK);
            end
        end
        S_VALID = 1'b0;
        wait_obs("rand", 24, 2000);
        for (int k = 0; k < 24; k++) begin
            cmp_burst($sformatf("rand%0d", k), k, fq[k]);
            if (k > 0 && k < obs.size())
                chk_ge($sformatf("rand%0d_gap", k), obs[k].idle, gap_of(fq[k-1].mode));
        end
        repeat (12) @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);

        chk("ed_glitches", 32'(ed_glitch), 32'd0);
        chk("idle_data_nonzero", 32'(data_nz), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rs_5_3_frame_feeder.md
# rs_5_3_frame_feeder

Upstream framing stage for the RS(5,3) GF(256) codec. Accepts a plain valid/ready byte stream, collects complete frames (3 message symbols to encode, 5 codeword symbols to decode) into a two-slot buffer, and launches each frame to the codec as one contiguous active-low `DATA_VALID_IN` burst. It enforces the idle gap the codec needs to finish parity or correction before the next burst, and holds `E_D` stable for the whole frame. This lets the codec be fed from a bursty or stalling source.

## Interface
- `ENC_GAP`, 2: minimum idle cycles (`DATA_VALID_IN`=1) after an encode burst.
- `DEC_GAP`, 6: minimum idle cycles after a decode burst.
- `CLK`  in  1  single clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `S_VALID`  in  1  upstream symbol valid.
- `S_READY`  out  1  feeder can accept a symbol.
- `S_DATA`  in  8  upstream symbol.
- `S_MODE`  in  1  1=encode frame, 0=decode frame; sampled with the first symbol of each frame.
- `DATA_VALID_IN`  out  1  to codec, active-low symbol strobe.
- `DATA_IN`  out  8  to codec symbol.
- `E_D`  out  1  to codec, 1=encode, 0=decode.
- `BUSY`  out  1  any slot occupied, or burst/gap in progress.
- `ERR_POS`  in  3  error-injection symbol index 0..4 (only with macro).
- `ERR_VAL`  in  8  error pattern XORed into that symbol (only with macro).

## Operation
- Symbol accepted on `S_VALID && S_READY`. The frame length N is 3 if the latched mode is 1, and 5 otherwise.
- Two frame slots, each holding 5×8 symbols, a mode bit and a full flag. The write slot fills until N symbols are stored, then is marked full, and the write pointer toggles.
- `S_READY` = write slot not full, and not in reset.
- The launch FSM has three states:
  - IDLE: when the read slot is full, go to BURST. `E_D` takes the slot's mode on the same edge.
  - BURST: drive symbols 0..N-1 in order, one per cycle, with `DATA_VALID_IN`=0. After the last symbol, free the slot, toggle the read pointer and go to GAP.
  - GAP: `DATA_VALID_IN`=1, `DATA_IN`=0, `E_D` held. Count `ENC_GAP` or `DEC_GAP` cycles according to the frame mode, then go to IDLE.
- `E_D` changes only on the IDLE→BURST edge and is otherwise held.
- A slot freed in the last BURST cycle may be refilled from the next cycle.
- If a symbol is accepted into slot A while slot B is being freed in the same cycle, both take effect. The full flags are independent per slot.
- `S_MODE` on symbols other than the first of a frame is ignored.

## Timing
- All outputs are registered.
- Reset values: `DATA_VALID_IN`=1, `DATA_IN`=0, `E_D`=1, `S_READY`=0, `BUSY`=0. Both slots are emptied and the FSM goes to IDLE.
- Reset asserted mid-burst truncates the burst. `DATA_VALID_IN`=1 in the first cycle after the reset edge. The partial frame is discarded and no gap is enforced.
- Latency: the first `DATA_VALID_IN`=0 cycle is 2 cycles after the edge that accepts the last symbol of a frame, provided the FSM is IDLE.
- The burst is exactly N consecutive low cycles, with no bubbles.
- Back-to-back encode frames: burst period is 3+`ENC_GAP` = 5 cycles. Back-to-back decode frames: 5+`DEC_GAP` = 11 cycles.
- `S_READY` is 0 only while both slots are full.

## Configuration
- `RS_FEEDER_ERR_INJ_EN` defined:
  - `ERR_POS` and `ERR_VAL` exist and are sampled with the first symbol of each decode frame.
  - During the burst, symbol index `ERR_POS` is XORed with `ERR_VAL`. `ERR_POS` > 4 or `ERR_VAL`=0 means no injection.
  - Encode frames are never modified.
- Not defined: the ports and logic are absent, and `DATA_IN` is the stored symbol unmodified.

## Structure
- Shared package `rs_5_3_pkg`:
  - constants `RS_ENC_LEN`=3, `RS_DEC_LEN`=5, `RS_SYM_W`=8;
  - FSM state enum {IDLE, BURST, GAP};
  - mode encoding constants `RS_MODE_ENC`=1, `RS_MODE_DEC`=0.
- Sub-module `rs_5_3_frame_slot_buf`: the two-slot storage with write/read pointers, full flags, and per-slot mode (and injection fields when enabled). The launch FSM and gap counter stay in the top level.

## Test plan
- Single encode: mode 1, symbols 0x50,0x00,0x00 → `E_D`=1, `DATA_VALID_IN`=0 for 3 cycles with `DATA_IN` 0x50,0x00,0x00, then ≥2 idle cycles. Codec parity symbols checked against the reference model.
- Back-to-back encode: 4 frames streamed continuously with `S_VALID`=1 → bursts start every 5 cycles, and `S_READY` never stalls longer than one frame.
- Decode frame: codeword from the encode test, fed with mode 0 → 5-cycle burst with `E_D`=0, then ≥6 idle cycles. Codec returns 0x50,0x00,0x00.
- Mode switch: encode frame immediately followed by a decode frame → `E_D` stays 1 through the encode gap and changes only on the decode burst's first cycle.
- Reset mid-burst: `RESET` asserted in the 2nd decode burst cycle → the next cycle shows `DATA_VALID_IN`=1, `S_READY`=0 while in reset, `BUSY`=0. A fresh frame after reset launches normally.
- With `RS_FEEDER_ERR_INJ_EN`: decode frame with `ERR_POS`=2, `ERR_VAL`=0xA5 → 3rd burst symbol is XORed with 0xA5, and the codec corrects it to the original message.
